// File: rtl/time_counter_pkg.sv
// Shared constants for the watch time-of-day path: BCD field positions in
// timer_data, digit limits and the run/set mode encoding.
package time_counter_pkg;

    localparam int DIGIT_W  = 4;
    localparam int FIELD_W  = 2 * DIGIT_W;
    localparam int SEC_LSB  = 0;
    localparam int MIN_LSB  = 8;
    localparam int HOUR_LSB = 16;
    localparam int TIME_W   = 24;
    localparam int PRE_W    = 26;

    localparam int SEC_TENS_MAX = 5;
    localparam int HOUR_MAX_24  = 23;
    localparam int HOUR_MAX_12  = 12;

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } state_t;

    function automatic logic [FIELD_W-1:0] to_bcd(input int n);
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
        tens = DIGIT_W'(n / 10);
        ones = DIGIT_W'(n % 10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter with configurable modulus. HOUR12 selects the
// 12, 01..11 clock-face sequence; carry_out marks the terminal increment.
module bcd_mod_counter
    import time_counter_pkg::*;
#(
    parameter int                 MODULUS = 60,
    parameter bit                 HOUR12  = 1'b0,
    parameter logic [FIELD_W-1:0] RST_VAL = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_inc,
    input  logic               i_clear,
    output logic [FIELD_W-1:0] o_value,
    output logic               o_carry
);

    // In 12-hour mode the carry (pm toggle) happens on 11 -> 12, while the
    // numeric wrap happens on 12 -> 01.
    localparam logic [FIELD_W-1:0] LAST  = to_bcd(MODULUS - 1);
    localparam logic [FIELD_W-1:0] TOP12 = to_bcd(MODULUS);

    logic [FIELD_W-1:0] r_value;
    logic [FIELD_W-1:0] w_next;

    always_comb begin
        w_next = r_value;
        if (HOUR12 && r_value == TOP12)
            w_next = to_bcd(1);
        else if (!HOUR12 && r_value == LAST)
            w_next = '0;
        else if (r_value[DIGIT_W-1:0] == 4'd9)
            w_next = {r_value[FIELD_W-1:DIGIT_W] + 4'd1, 4'd0};
        else
            w_next = {r_value[FIELD_W-1:DIGIT_W], r_value[DIGIT_W-1:0] + 4'd1};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_value <= RST_VAL;
        else if (i_clear)
            r_value <= RST_VAL;
        else if (i_inc)
            r_value <= w_next;
    end

    assign o_value = r_value;
    assign o_carry = i_inc && !i_clear && (r_value == LAST);

endmodule

// File: rtl/time_counter.sv
// Time-of-day counter: 1 Hz prescaler plus packed-BCD hh:mm:ss with a set mode.
// Define TIME_COUNTER_HOUR12_EN for the 12-hour clock with a pm output.
module time_counter
    import time_counter_pkg::*;
#(
    parameter int data_width = 23,
    parameter int second_cnt = 52428800
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                set_mode,
    input  logic                inc_hour,
    input  logic                inc_minute,
    output logic [data_width:0] timer_data,
    output logic                second_pulse,
    output logic                day_pulse
`ifdef TIME_COUNTER_HOUR12_EN
    ,
    output logic                pm
`endif
);

`ifdef TIME_COUNTER_HOUR12_EN
    localparam int                 HOUR_MOD  = HOUR_MAX_12;
    localparam bit                 HOUR_12   = 1'b1;
    localparam logic [FIELD_W-1:0] HOUR_RST  = to_bcd(HOUR_MAX_12);
`else
    localparam int                 HOUR_MOD  = HOUR_MAX_24 + 1;
    localparam bit                 HOUR_12   = 1'b0;
    localparam logic [FIELD_W-1:0] HOUR_RST  = '0;
`endif
    localparam int               MS_MOD   = (SEC_TENS_MAX + 1) * 10;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(second_cnt - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic               w_run_en;
    logic               w_set_en;
    logic [PRE_W-1:0]   r_presc;
    logic               w_tick;
    logic               w_day;
    logic               r_second_pulse;
    logic               r_day_pulse;
    logic [FIELD_W-1:0] w_sec;
    logic [FIELD_W-1:0] w_min;
    logic [FIELD_W-1:0] w_hour;
    logic               w_sec_carry;
    logic               w_min_carry;
    logic               w_hour_carry;
    logic               w_min_inc;
    logic               w_hour_inc;
    logic [TIME_W-1:0]  w_packed;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= RUN;
        else
            r_state <= w_next_state;
    end

    // Mode enables follow set_mode in the same cycle so a mode change acts
    // on the very next edge.
    always_comb begin
        w_next_state = r_state;
        w_run_en     = 1'b0;
        w_set_en     = 1'b0;
        case (r_state)
            RUN: begin
                if (set_mode) begin
                    w_next_state = SET;
                    w_set_en     = 1'b1;
                end else begin
                    w_run_en     = 1'b1;
                end
            end
            SET: begin
                if (!set_mode) begin
                    w_next_state = RUN;
                    w_run_en     = 1'b1;
                end else begin
                    w_set_en     = 1'b1;
                end
            end
        endcase
    end

    assign w_tick = w_run_en && (r_presc == PRE_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_presc <= '0;
        else if (!w_run_en || w_tick)
            r_presc <= '0;
        else
            r_presc <= r_presc + 1'b1;
    end

    // Minute rollover in set mode must not reach the hours.
    assign w_min_inc  = w_sec_carry | (w_set_en & inc_minute);
    assign w_hour_inc = (w_run_en & w_min_carry) | (w_set_en & inc_hour);

    bcd_mod_counter #(.MODULUS(MS_MOD), .HOUR12(1'b0), .RST_VAL('0)) u_sec (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (w_tick),
        .i_clear (w_set_en),
        .o_value (w_sec),
        .o_carry (w_sec_carry)
    );

    bcd_mod_counter #(.MODULUS(MS_MOD), .HOUR12(1'b0), .RST_VAL('0)) u_min (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (w_min_inc),
        .i_clear (1'b0),
        .o_value (w_min),
        .o_carry (w_min_carry)
    );

    bcd_mod_counter #(.MODULUS(HOUR_MOD), .HOUR12(HOUR_12), .RST_VAL(HOUR_RST)) u_hour (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (w_hour_inc),
        .i_clear (1'b0),
        .o_value (w_hour),
        .o_carry (w_hour_carry)
    );

`ifdef TIME_COUNTER_HOUR12_EN
    logic r_pm;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_pm <= 1'b0;
        else if (w_hour_carry)
            r_pm <= ~r_pm;
    end

    assign w_day = w_run_en & w_hour_carry & r_pm;
    assign pm    = r_pm;
`else
    assign w_day = w_run_en & w_hour_carry;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_second_pulse <= 1'b0;
            r_day_pulse    <= 1'b0;
        end else begin
            r_second_pulse <= w_tick;
            r_day_pulse    <= w_day;
        end
    end

    always_comb begin
        w_packed                     = '0;
        w_packed[SEC_LSB  +: FIELD_W] = w_sec;
        w_packed[MIN_LSB  +: FIELD_W] = w_min;
        w_packed[HOUR_LSB +: FIELD_W] = w_hour;
    end

    assign timer_data   = (data_width + 1)'(w_packed);
    assign second_pulse = r_second_pulse;
    assign day_pulse    = r_day_pulse;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter (24-hour build, second_cnt = 4): vector
// table for single-cycle behaviour plus sequences for multi-second cases.
module tb_time_counter;

    localparam int SC = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        set_mode = 1'b0;
    logic        inc_hour = 1'b0;
    logic        inc_minute = 1'b0;
    logic [23:0] timer_data;
    logic        second_pulse;
    logic        day_pulse;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sm;
        logic        ih;
        logic        im;
        logic [23:0] exp_t;
        logic        exp_sp;
        logic        exp_dp;
    } vec_t;

    vec_t tbl [19];

    time_counter #(.data_width(23), .second_cnt(SC)) dut (
        .clock        (clock),
        .reset        (reset),
        .set_mode     (set_mode),
        .inc_hour     (inc_hour),
        .inc_minute   (inc_minute),
        .timer_data   (timer_data),
        .second_pulse (second_pulse),
        .day_pulse    (day_pulse)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_tbl(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            set_mode   = tbl[i].sm;
            inc_hour   = tbl[i].ih;
            inc_minute = tbl[i].im;
            step();
            chk($sformatf("row%0d_time", i), timer_data, tbl[i].exp_t);
            chk($sformatf("row%0d_sec_pulse", i), {23'd0, second_pulse}, {23'd0, tbl[i].exp_sp});
            chk($sformatf("row%0d_day_pulse", i), {23'd0, day_pulse}, {23'd0, tbl[i].exp_dp});
        end
        inc_hour   = 1'b0;
        inc_minute = 1'b0;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (second_pulse !== 1'b1 && n < 3 * SC);
        if (second_pulse !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: got no second_pulse within %0d cycles, required one", 3 * SC);
        end
    endtask

    task automatic set_time(input int h, input int m);
        set_mode = 1'b1;
        step();
        repeat (h) begin
            inc_hour = 1'b1; step();
            inc_hour = 1'b0; step();
        end
        repeat (m) begin
            inc_minute = 1'b1; step();
            inc_minute = 1'b0; step();
        end
    endtask

    initial begin
        // run from reset: first tick on the 4th edge
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 24'h000001, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 24'h000001, 1'b0, 1'b0};
        // set mode from 10:25:37
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 24'h102500, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 24'h102600, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 24'h102600, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 24'h102700, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 24'h102800, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 24'h112900, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 24'h112900, 1'b0, 1'b0};
        // set mode from 23:59:00: no hour carry, quiet hour wrap
        tbl[12] = '{1'b1, 1'b0, 1'b1, 24'h230000, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0};
        // run mode ignores the buttons (prescaler at 1 when this starts)
        tbl[15] = '{1'b0, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 24'h000000, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 1'b1, 24'h000001, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 24'h000001, 1'b0, 1'b0};

        #1 reset = 1'b1;
        #1;
        chk("reset_time", timer_data, 24'h000000);
        chk("reset_sec_pulse", {23'd0, second_pulse}, 24'd0);
        chk("reset_day_pulse", {23'd0, day_pulse}, 24'd0);
        step();
        reset = 1'b0;

        run_tbl(0, 4);

        repeat (58) wait_tick();
        chk("at_000059", timer_data, 24'h000059);
        wait_tick();
        chk("minute_carry", timer_data, 24'h000100);

        set_time(10, 24);
        chk("set_1025", timer_data, 24'h102500);
        set_mode = 1'b0;
        repeat (SC - 1) step();
        chk("leave_set_no_tick_yet", timer_data, 24'h102500);
        chk("leave_set_no_pulse_yet", {23'd0, second_pulse}, 24'd0);
        step();
        chk("leave_set_first_tick", timer_data, 24'h102501);
        chk("leave_set_first_pulse", {23'd0, second_pulse}, 24'd1);
        repeat (36) wait_tick();
        chk("at_102537", timer_data, 24'h102537);

        run_tbl(5, 11);

        set_time(12, 30);
        chk("set_2359", timer_data, 24'h235900);
        run_tbl(12, 14);

        set_time(23, 59);
        chk("set_2359_again", timer_data, 24'h235900);
        set_mode = 1'b0;
        repeat (59) wait_tick();
        chk("at_235959", timer_data, 24'h235959);
        chk("no_early_day_pulse", {23'd0, day_pulse}, 24'd0);
        wait_tick();
        chk("day_wrap_time", timer_data, 24'h000000);
        chk("day_wrap_pulse", {23'd0, day_pulse}, 24'd1);
        step();
        chk("day_pulse_one_cycle", {23'd0, day_pulse}, 24'd0);

        run_tbl(15, 18);

        set_time(5, 5);
        set_mode = 1'b0;
        repeat (5) wait_tick();
        chk("at_050505", timer_data, 24'h050505);
        step();
        step();
        #3 reset = 1'b1;
        #1;
        chk("async_reset_time", timer_data, 24'h000000);
        chk("async_reset_sec_pulse", {23'd0, second_pulse}, 24'd0);
        step();
        reset = 1'b0;
        repeat (SC - 1) step();
        chk("post_reset_no_tick_yet", timer_data, 24'h000000);
        step();
        chk("post_reset_first_tick", timer_data, 24'h000001);
        chk("post_reset_pulse", {23'd0, second_pulse}, 24'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_counter.md
Name: time_counter

Overview:
- Time-of-day counter for the digital watch.
- Divides the system clock to a 1 Hz tick and keeps hours:minutes:seconds as packed BCD.
- Its timer_data output feeds the alarm comparator, which checks it against alarm_data, and the display path.
- Has a set mode in which hours and minutes are advanced by single-cycle button pulses that are already debounced and pulse-shaped upstream.

Parameters:
- data_width, 23: MSB index of timer_data (24-bit packed BCD).
- second_cnt, 52428800: clock cycles per second tick; must be >= 2; reduced (e.g. 4) in simulation.

Ports:
- clock  input  1  system clock, all state on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- set_mode  input  1  1 = time-setting mode; level signal.
- inc_hour  input  1  single-cycle pulse; in set mode, advances hours by one.
- inc_minute  input  1  single-cycle pulse; in set mode, advances minutes by one.
- timer_data  output  data_width+1  {h_tens, h_ones, m_tens, m_ones, s_tens, s_ones}, 4 bits BCD each.
- second_pulse  output  1  one-cycle pulse each time seconds advance in run mode.
- day_pulse  output  1  one-cycle pulse on wrap 23:59:59 -> 00:00:00.

Behaviour:
- Reset (async, active-high):
  - prescaler = 0; timer_data = 24'h000000; second_pulse = 0; day_pulse = 0.
  - Reset mid-operation discards any partial second.
- Prescaler, 26-bit:
  - Run mode: counts 0..second_cnt-1. On the cycle it equals second_cnt-1 it returns to 0 and asserts tick internally.
  - Set mode: held at 0.
- Run mode (set_mode = 0):
  - On tick, seconds increment in BCD. s_ones wraps 9 -> 0 and carries into s_tens; s_tens wraps 5 -> 0 and carries into minutes.
  - Minutes follow the same rule and carry into hours.
  - Hours count 00..23. 23 -> 00 wraps and asserts day_pulse.
- Latency:
  - timer_data, second_pulse and day_pulse are all registered.
  - They change on the clock edge where the prescaler returns to 0.
  - The pulses are high for exactly that one cycle.
- Set mode (set_mode = 1):
  - Seconds held at 00.
  - inc_minute: minutes +1 mod 60, no carry into hours.
  - inc_hour: hours +1 mod 24.
  - inc_hour and inc_minute in the same cycle: both apply independently.
  - second_pulse and day_pulse stay 0, including on the hour wrap 23 -> 00.
  - Result visible on timer_data the cycle after the pulse.
- Run mode: inc_hour and inc_minute are ignored.
- Leaving set mode (1 -> 0): the prescaler starts from 0, so the first tick is second_cnt cycles after the first run-mode cycle.
- Entering set mode mid-second: the partial second is discarded and seconds are cleared to 00 on the next edge.
- BCD invariant: no digit ever holds an illegal value. Maxima: s_tens/m_tens 5, h_tens 2, h_ones 3 when h_tens = 2.
- State machine (2 states):
  - RUN -> SET when set_mode = 1; SET -> RUN when set_mode = 0.
  - The state register is updated every cycle; outputs are decoded from state.

Optional Feature:
- Macro: TIME_COUNTER_HOUR12_EN.
- Defined:
  - Hours count 12, 01..11, with an added output port pm (1 bit).
  - Reset value 12:00:00 with pm = 0.
  - 11:59:59 -> 12:00:00 toggles pm.
  - day_pulse fires on the 11:59:59 pm=1 -> 12:00:00 pm=0 transition.
  - inc_hour follows the same 12-hour sequence, toggling pm at 11 -> 12 (day_pulse suppressed in set mode as in 24-hour mode).
- Undefined: 24-hour behaviour as above; no pm port.

Decomposition:
- Shared package:
  - Constants for BCD digit field positions within timer_data.
  - Digit limits: SEC_TENS_MAX = 5, HOUR_MAX_24 = 23, HOUR_MAX_12 = 12.
  - State encoding: RUN, SET.
- The alarm comparator imports the same digit-position constants.
- One natural sub-module: bcd_mod_counter, a two-digit BCD counter.
  - Parameter: modulus.
  - Inputs: inc, clear.
  - Outputs: value, carry_out.
  - Instantiated for seconds (60), minutes (60) and hours (24, or 12-hour variant).

Test Plan:
- Reset, second_cnt = 4, run 4 cycles -> timer_data = 24'h000001; second_pulse high exactly 1 cycle on that edge.
- Run to 00:00:59, one more tick -> 24'h000100. Run to 23:59:59, one more tick -> 24'h000000 with day_pulse = 1 for exactly 1 cycle.
- set_mode = 1 at 10:25:37 -> 24'h102500 next cycle. Three inc_minute pulses -> 102800. inc_hour and inc_minute in the same cycle -> 112900.
- Set mode at 23:59:00, inc_minute -> 23:00:00 (no hour carry); inc_hour -> 00:00:00; day_pulse stays 0 throughout.
- inc_hour pulse in run mode -> timer_data unchanged. Leave set mode -> first increment exactly second_cnt cycles later.
- Assert reset asynchronously mid-second at 05:05:05 -> timer_data = 0 before the next clock edge; prescaler restarts from 0 after release.
